// File: rtl/mod_dds_pkg.sv
// mod_dds_pkg: shared CTRL bit indices, FSM state type and mem_dout field offsets for mod_dds_v2
package mod_dds_pkg;
  localparam int CTRL_PM  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_AM  = 2;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  typedef enum logic [2:0] {F_C0, F_G, F_AC0, F_AC1, F_POFF, F_CTRL, F_END} field_t;
  function automatic int field_off(input int nc, input int bc, input int ba, input field_t f);
    return f == F_G    ? nc * bc :
           f == F_AC0  ? (nc + 1) * bc :
           f == F_AC1  ? (nc + 1) * bc + ba :
           f == F_POFF ? (nc + 1) * bc + 2 * ba :
           f == F_CTRL ? (nc + 2) * bc + 2 * ba :
           f == F_END  ? (nc + 2) * bc + 2 * ba + 8 : 0;
  endfunction
endpackage

// File: rtl/mod_dds_horner_stage.sv
// mod_dds_horner_stage: registered y = narrow(a + ((h * m) >>> SH)) to BF signed bits
// Ports: clk; a addend; h running value; m signed multiplier; y registered result.
// MOD_DDS_SAT_EN defined: result saturates to the BF range; otherwise it wraps.
module mod_dds_horner_stage #(
  parameter int BF = 19,
  parameter int BM = 17,
  parameter int SH = 16
)(
  input  logic                 clk,
  input  logic signed [BF-1:0] a,
  input  logic signed [BF-1:0] h,
  input  logic signed [BM-1:0] m,
  output logic signed [BF-1:0] y
);
  localparam int BP = BF + BM;
  logic signed [BP-1:0] p;
  logic signed [BP:0] s;
  always_comb begin
    p = h * m;
    s = (BP+1)'(a) + (BP+1)'(p >>> SH);
  end
`ifdef MOD_DDS_SAT_EN
  localparam logic signed [BF-1:0] hi = {1'b0, {(BF-1){1'b1}}};
  localparam logic signed [BF-1:0] lo = {1'b1, {(BF-1){1'b0}}};
  always_ff @(posedge clk) y <= s > (BP+1)'(hi) ? hi : s < (BP+1)'(lo) ? lo : BF'(s);
`else
  always_ff @(posedge clk) y <= BF'(s);
`endif
endmodule

// File: rtl/mod_dds_v2.sv
// mod_dds_v2: pipelined Horner FM/PM phase and AM amplitude front end with double-buffered parameters
// Ports: clk, rstn (sync, active low); mem_dout/mem_valid parameter word and load strobe;
// t_in unsigned time base; phase_out, amp_out, dout_valid sample outputs (NC+2 cycle latency).
// MOD_DDS_SAT_EN selects saturating instead of wrapping Horner and gain stages.
module mod_dds_v2
  import mod_dds_pkg::*;
#(
  parameter int BT  = 16,
  parameter int NC  = 6,
  parameter int BC  = 18,
  parameter int BA  = 16,
  parameter int BPH = 32,
  parameter int MW  = 256
)(
  input  logic           clk,
  input  logic           rstn,
  input  logic [MW-1:0]  mem_dout,
  input  logic           mem_valid,
  input  logic [BT-1:0]  t_in,
  output logic [BPH-1:0] phase_out,
  output logic [BA-1:0]  amp_out,
  output logic           dout_valid
);
  localparam int BF  = BC + 1;
  localparam int BW  = BA + BT + 2;
  localparam int OG  = field_off(NC, BC, BA, F_G);
  localparam int OA0 = field_off(NC, BC, BA, F_AC0);
  localparam int OA1 = field_off(NC, BC, BA, F_AC1);
  localparam int OP  = field_off(NC, BC, BA, F_POFF);
  localparam int OC  = field_off(NC, BC, BA, F_CTRL);
  localparam int UW  = field_off(NC, BC, BA, F_END);
  localparam logic signed [BA-1:0] am_hi = {1'b0, {(BA-1){1'b1}}};
  localparam logic signed [BA-1:0] am_lo = {1'b1, {(BA-1){1'b0}}};
  state_t state, state_nx;
  logic t0, load, pend, v_in;
  logic [UW-1:0] pend_w, act_w, cur_w;
  logic [UW-1:0] w [NC+1];
  logic [BT-1:0] t [NC+1];
  logic [NC:0] v;
  logic signed [BF-1:0] h [NC+1];
  logic [7:0] ctrl;
  logic signed [BA-1:0] ac0, ac1, am;
  logic signed [BW-1:0] am_p, am_s;
  logic [BPH-1:0] acc, acc_base, fs_x, poff_x;
  logic unused_bits;
  always_ff @(posedge clk) state <= !rstn ? IDLE : state_nx;
  // A boundary sample (t_in == 0) activates a pending or simultaneously arriving word.
  always_comb begin
    t0 = t_in == '0;
    load = t0 && (mem_valid || pend);
    state_nx = load ? RUN : state == IDLE && mem_valid ? ARMED : state;
  end
  always_comb begin
    v_in = state_nx == RUN;
    cur_w = load ? (mem_valid ? mem_dout[UW-1:0] : pend_w) : act_w;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      pend <= 1'b0;
      pend_w <= '0;
      act_w <= '0;
      v <= '0;
    end else begin
      pend <= !t0 && (mem_valid || pend);
      pend_w <= mem_valid ? mem_dout[UW-1:0] : pend_w;
      act_w <= load ? cur_w : act_w;
      v <= {v[NC-1:0], v_in};
    end
  // Every stage carries its sample's own parameter word so a switch never splits a sample.
  always_ff @(posedge clk) begin
    w[0] <= cur_w;
    t[0] <= t_in;
    for (int i = 1; i <= NC; i++) begin
      w[i] <= w[i-1];
      t[i] <= t[i-1];
    end
  end
  assign h[0] = BF'($signed(w[0][(NC-1)*BC +: BC]));
  for (genvar j = 1; j < NC; j++) begin : g_st
    mod_dds_horner_stage #(.BF(BF), .BM(BT+1), .SH(BT)) u_st (
      .clk(clk),
      .a(BF'($signed(w[j-1][(NC-1-j)*BC +: BC]))),
      .h(h[j-1]),
      .m($signed({1'b0, t[j-1]})),
      .y(h[j])
    );
  end
  mod_dds_horner_stage #(.BF(BF), .BM(BC), .SH(16)) u_gain (
    .clk(clk),
    .a('0),
    .h(h[NC-1]),
    .m($signed(w[NC-1][OG +: BC])),
    .y(h[NC])
  );
  always_comb begin
    ctrl = w[NC][OC +: 8];
    ac0 = $signed(w[NC][OA0 +: BA]);
    ac1 = $signed(w[NC][OA1 +: BA]);
    fs_x = BPH'(h[NC]);
    poff_x = BPH'($signed(w[NC][OP +: BC]));
    acc_base = ctrl[CTRL_CLR] && t[NC] == '0 ? '0 : acc;
    am_p = ac1 * $signed({1'b0, t[NC]});
    am_s = BW'(ac0) + (am_p >>> BT);
    am = !ctrl[CTRL_AM] ? ac0 : am_s > BW'(am_hi) ? am_hi : am_s < BW'(am_lo) ? am_lo : BA'(am_s);
  end
  assign unused_bits = ^{mem_dout[MW-1:UW], ctrl[7:3], w[NC]};
  always_ff @(posedge clk)
    if (!rstn) begin
      acc <= '0;
      phase_out <= '0;
      amp_out <= '0;
      dout_valid <= 1'b0;
    end else begin
      acc <= v[NC] && !ctrl[CTRL_PM] ? acc_base + fs_x : acc;
      phase_out <= !v[NC] ? '0 : ctrl[CTRL_PM] ? fs_x + poff_x : acc_base + poff_x;
      amp_out <= v[NC] ? am : '0;
      dout_valid <= v[NC];
    end
endmodule

// File: doc/mod_dds_v2.md
# mod_dds_v2

Parametrised successor to the single-channel modulated DDS front end. It consumes a packed parameter word from the waveform memory and a free-running time base. Per sample it evaluates a pipelined Horner polynomial for frequency or phase and a linear amplitude ramp, and emits phase and amplitude words to the downstream sine generator. It adds three things over the previous generation:
- configurable polynomial order and widths;
- double-buffered, glitch-free parameter switching;
- selectable FM/PM and AM modes.

## Interface
- BT, 16: bits of time base t.
- NC, 6: number of frequency coefficients C0..C(NC-1), 2..8.
- BC, 18: coefficient, gain and POFF width (signed).
- BA, 16: amplitude width (signed).
- BPH, 32: phase output width.
- MW, 256: mem_dout width. Used bits are packed from the LSB: C0..C(NC-1), G, AC0, AC1, POFF, CTRL[7:0]. Upper bits are ignored.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- mem_dout  in  MW  parameter word.
- mem_valid  in  1  one-cycle strobe; latches mem_dout.
- t_in  in  BT  time base, unsigned.
- phase_out  out  BPH  phase word.
- amp_out  out  BA  amplitude word.
- dout_valid  out  1  high while outputs carry a valid sample.

## Operation
- tn = t_in / 2^BT, unsigned fraction.
- Horner width BF = BC+1, signed:
  - h = C(NC-1);
  - for k = NC-2 down to 0: h = Ck + ((h*tn) >>> BT).
  - Each stage result is narrowed to BF bits.
- Gain: fs = (h*G) >>> 16, narrowed to BF. G = 65536 is unity gain.
- CTRL[0] selects the phase mode:
  - 0 = FM: acc <= acc + sext(fs); phase_out = acc + sext(POFF), using the acc value before the add.
  - 1 = PM: phase_out = sext(fs) + sext(POFF).
  - All terms are LSB-aligned and wrap modulo 2^BPH.
- CTRL[1] = 1: acc clears to 0 when the sample with t_in == 0 enters the accumulate stage.
- CTRL[2] selects the amplitude mode:
  - 1: amp = AC0 + ((AC1*tn) >>> BT), saturated to BA.
  - 0: amp = AC0.
- CTRL[7:3] are reserved and ignored.
- FSM:
  - IDLE: no word loaded. Outputs are 0 and dout_valid = 0. mem_valid moves to ARMED.
  - ARMED: the word is held in the pending register. It becomes active on the first cycle with t_in == 0, and the FSM moves to RUN.
  - RUN: mem_valid writes the pending register and sets pend. At the next t_in == 0 the pending word becomes active and pend clears.
- Simultaneous mem_valid and t_in == 0: the new word is active for that same sample.
- A second mem_valid before the boundary overwrites the pending word; only the last one is applied.
- Each pipeline stage carries its copy of the remaining coefficients, G, POFF, AC0, AC1 and CTRL with the sample. A switch therefore never mixes two parameter sets within one sample.

## Timing
- Latency LAT = NC+2 edges. A sample taken at edge k appears on the outputs after edge k+NC+1.
- The AM path is delay-matched to the phase path.
- dout_valid rises LAT cycles after the first activation and then stays high; t_in does not stall.
- Reset, including mid-operation, takes effect at the next edge:
  - FSM goes to IDLE; pending and active words are cleared;
  - pipeline valids, acc, phase_out and amp_out go to 0; dout_valid goes to 0.
- Reset dominates mem_valid in the same cycle.

## Configuration
- MOD_DDS_SAT_EN defined: Horner and gain stages saturate to the BF range [-2^BC, 2^BC-1].
- MOD_DDS_SAT_EN undefined: those stages wrap (two's-complement truncation).
- Amplitude saturation is always present.

## Structure
- Package mod_dds_pkg holds:
  - the CTRL bit index constants;
  - a typedef for the FSM state enum (IDLE, ARMED, RUN);
  - a function computing field offsets within mem_dout from NC, BC and BA.
- Sub-module mod_dds_horner_stage: one multiply-add stage (BF/BT widths, optional saturation), instantiated NC-1 times by generate.

## Test plan
- Reset: rstn low for 5 cycles with mem_valid pulsing -> phase_out = 0, amp_out = 0, dout_valid = 0; FSM stays IDLE after release until a new mem_valid.
- FM constant: C0 = 1000, other C = 0, G = 65536, CTRL = 0x02, POFF = 0; mem_valid at t_in = 5 -> from the t_in == 0 sample, phase_out = 0, 1000, 2000, … with dout_valid high LAT cycles after that sample.
- PM ramp: CTRL = 0x01, C1 = 16384, other C = 0, G = 65536 -> phase_out = 8192 for t_in = 32768.
- AM: CTRL = 0x04, AC0 = 32440, AC1 = -16056 -> amp_out = 24412 at t_in = 32768 and 16384 at t_in = 65535.
- Saturation: C0 = C1 = C2 = 131071, NC = 3, G = 65536, PM, t_in = 65535:
  - with MOD_DDS_SAT_EN: phase_out = 262143;
  - without: phase_out = -131081 sign-extended.
- Switch: running FM with C0 = 1000; mem_valid (C0 = 2000) at t_in = 100, then mem_valid (C0 = 3000) at t_in = 200 -> step stays 1000 until the t_in == 0 sample, then becomes 3000; no sample ever shows 2000.
